pipelined_cla_subtractor: RTL and testbench



---
 rtl/pipelined_cla_subtractor_if.sv | 24 ++
 rtl/pipelined_cla_subtractor.sv | 122 ++++++++++++
 tb/tb_pipelined_cla_subtractor.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_subtractor_if.sv
// Operand/result handshake bundle for the pipelined CLA subtractor.
// The master side produces operands and consumes results; the slave side is the subtractor.
interface pipelined_cla_subtractor_if;
    logic signed [31:0] A;
    logic signed [31:0] B;
    logic               Bin;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] DIFF;
    logic               Bout;
    logic               Overflow;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output A, B, Bin, in_valid, out_ready,
        input  in_ready, DIFF, Bout, Overflow, out_valid
    );

    modport slave (
        input  A, B, Bin, in_valid, out_ready,
        output in_ready, DIFF, Bout, Overflow, out_valid
    );
endinterface

// File: rtl/pipelined_cla_subtractor.sv
// Four-stage 32-bit subtractor A - B - Bin built as A + ~B + ~Bin, one 8-bit
// carry-look-ahead slice per stage, with a global valid/ready stall.
module pipelined_cla_subtractor (
    input  logic                        clk,
    input  logic                        rst_n,
    pipelined_cla_subtractor_if.slave   bus
);
    localparam int DATA_W = 32;

    // Carries are expanded as flat generate/propagate products rather than rippled.
    function automatic logic [8:0] cla_slice(input logic [7:0] a,
                                             input logic [7:0] bn,
                                             input logic       cin);
        logic [7:0] g;
        logic [7:0] p;
        logic [8:0] c;
        logic       acc;
        logic       pp;
        g    = a & bn;
        p    = a ^ bn;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (g[j] & pp);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (cin & pp);
        end
        return {c[8], p ^ c[7:0]};
    endfunction

    logic                     w_stall;
    logic                     w_adv;
    logic [8:0]               w_s0;
    logic [8:0]               w_s1;
    logic [8:0]               w_s2;
    logic [8:0]               w_s3;

    logic                     r_vld_p1;
    logic                     r_vld_p2;
    logic                     r_vld_p3;
    logic                     r_vld_p4;

    logic [31:8]              r_a_p1;
    logic [31:8]              r_bn_p1;
    logic [7:0]               r_diff_p1;
    logic                     r_c_p1;
    logic [31:16]             r_a_p2;
    logic [31:16]             r_bn_p2;
    logic [15:0]              r_diff_p2;
    logic                     r_c_p2;
    logic [31:24]             r_a_p3;
    logic [31:24]             r_bn_p3;
    logic [23:0]              r_diff_p3;
    logic                     r_c_p3;
    logic signed [DATA_W-1:0] r_diff_p4;
    logic                     r_bout_p4;
    logic                     r_ovf_p4;

    assign w_stall = r_vld_p4 & ~bus.out_ready;
    assign w_adv   = ~w_stall;

    assign w_s0 = cla_slice(bus.A[7:0], ~bus.B[7:0], ~bus.Bin);
    assign w_s1 = cla_slice(r_a_p1[15:8], r_bn_p1[15:8], r_c_p1);
    assign w_s2 = cla_slice(r_a_p2[23:16], r_bn_p2[23:16], r_c_p2);
    assign w_s3 = cla_slice(r_a_p3[31:24], r_bn_p3[31:24], r_c_p3);

    // Stages 1-3: operand skew registers, loaded only behind a valid token.
    always_ff @(posedge clk) begin
        if (w_adv && bus.in_valid) begin
            r_a_p1    <= bus.A[31:8];
            r_bn_p1   <= ~bus.B[31:8];
            r_diff_p1 <= w_s0[7:0];
            r_c_p1    <= w_s0[8];
        end
        if (w_adv && r_vld_p1) begin
            r_a_p2    <= r_a_p1[31:16];
            r_bn_p2   <= r_bn_p1[31:16];
            r_diff_p2 <= {w_s1[7:0], r_diff_p1};
            r_c_p2    <= w_s1[8];
        end
        if (w_adv && r_vld_p2) begin
            r_a_p3    <= r_a_p2[31:24];
            r_bn_p3   <= r_bn_p2[31:24];
            r_diff_p3 <= {w_s2[7:0], r_diff_p2};
            r_c_p3    <= w_s2[8];
        end
    end

    // Stage 4 and the valid chain; the visible outputs clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_vld_p3  <= 1'b0;
            r_vld_p4  <= 1'b0;
            r_diff_p4 <= '0;
            r_bout_p4 <= 1'b0;
            r_ovf_p4  <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1 <= bus.in_valid;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
            r_vld_p4 <= r_vld_p3;
            if (r_vld_p3) begin
                r_diff_p4 <= {w_s3[7:0], r_diff_p3};
                r_bout_p4 <= ~w_s3[8];
                // ~bn[31] is B[31]; overflow needs differing signs and a result sign flip.
                r_ovf_p4  <= (r_a_p3[31] ^ ~r_bn_p3[31]) & (w_s3[7] ^ r_a_p3[31]);
            end
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld_p4;
    assign bus.DIFF      = r_diff_p4;
    assign bus.Bout      = r_bout_p4;
    assign bus.Overflow  = r_ovf_p4;
endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Randomised and directed bench for pipelined_cla_subtractor, checked against an
// arithmetic reference model and a queue of accepted operations.
module tb_pipelined_cla_subtractor;
    typedef struct {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_cla_subtractor_if bus();

    pipelined_cla_subtractor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   rdy_mode = 0;
    int   pc = 0;
    bit   pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    exp_t q[$];

    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic bin);
        exp_t   r;
        longint sa, sb, sd, ua, ub, lb;
        sa = $signed(a);
        sb = $signed(b);
        lb = bin ? 64'sd1 : 64'sd0;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sd = sa - sb - lb;
        r.d  = sd[31:0];
        r.bo = (ua < ub + lb);
        r.ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // out_ready driver
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: begin bus.out_ready = pat[pc % 7]; pc++; end
                2: bus.out_ready = ($urandom_range(0, 99) < 60);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Compare process: one look per cycle, away from the rising edge.
    initial begin
        logic        prev_stall;
        logic [31:0] pd;
        logic        pb, po;
        exp_t        e;
        prev_stall = 1'b0;
        pd = '0; pb = 1'b0; po = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                prev_stall = 1'b0;
            end else begin
                chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
                if (prev_stall) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_diff", bus.DIFF, pd);
                    chk("hold_bout", bus.Bout, pb);
                    chk("hold_ovf", bus.Overflow, po);
                end
                if (bus.out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_out", bus.out_valid, 0);
                    end else begin
                        e = q[0];
                        chk("diff", bus.DIFF, e.d);
                        chk("bout", bus.Bout, e.bo);
                        chk("ovf", bus.Overflow, e.ov);
                        if (bus.out_ready) begin
                            void'(q.pop_front());
                            n_out++;
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready)
                    q.push_back(model(bus.A, bus.B, bus.Bin));
                prev_stall = bus.out_valid && !bus.out_ready;
                pd = bus.DIFF;
                pb = bus.Bout;
                po = bus.Overflow;
            end
        end
    end

    // Called and returning just after a rising edge; holds in_valid until accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic acc;
        bus.A = a;
        bus.B = b;
        bus.Bin = bin;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for 64 cycles, required 1");
    endtask

    task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic bin, input logic [31:0] xd, input logic xb,
                           input logic xo);
        int   edges;
        logic seen;
        send(a, b, bin);
        edges = 1;
        seen  = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                edges++;
            end
        end
        chk({nm, "_latency"}, edges, 4);
        chk({nm, "_diff"}, bus.DIFF, xd);
        chk({nm, "_bout"}, bus.Bout, xb);
        chk({nm, "_ovf"}, bus.Overflow, xo);
        @(negedge clk);
        chk({nm, "_onecycle"}, bus.out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
        #1;
        chk(nm, q.size(), 0);
    endtask

    initial begin
        int start;
        rst_n = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Bin = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_diff", bus.DIFF, 0);
        chk("rst_bout", bus.Bout, 0);
        chk("rst_ovf", bus.Overflow, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_one("5m3", 32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0);
        run_one("0m1", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_one("0m0b", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_one("minm1", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_one("maxmneg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        run_one("chain", 32'h0100_0000, 32'd1, 1'b0, 32'h00FF_FFFF, 1'b0, 1'b0);

        // Back-to-back stream under a fixed out_ready pattern.
        pc = 0;
        rdy_mode = 1;
        start = n_out;
        for (int i = 0; i < 8; i++) send(32'(100 * i), 32'(i), 1'b0);
        drain("stream_drain");
        chk("stream_count", n_out - start, 8);

        // Mid-operation reset with three operations in flight.
        rdy_mode = 3;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(32'(1000 + i), 32'(i), 1'b0);
        @(posedge clk);
        #2;
        chk("prerst_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_diff", bus.DIFF, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        #4;
        rst_n = 1'b1;
        rdy_mode = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("postrst_quiet", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
        run_one("9m4", 32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0);

        // Randomised traffic with random back-pressure.
        rdy_mode = 2;
        start = n_out;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
            else begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
